// File: rtl/sfu_lut_pkg.sv
// Shared types and constants for the SFU lookup-ROM port arbiters.
// The lane tag is sized for the widest supported lane count, so any N_REQ from 2 to 8 fits.
package sfu_lut_pkg;

  localparam int LUT_ADDR_WIDTH = 5;
  localparam int LUT_DATA_WIDTH = 20;
  localparam int LUT_LATENCY    = 1;
  localparam int SFU_MAX_REQ    = 8;

  typedef logic [$clog2(SFU_MAX_REQ)-1:0] lane_idx_t;

  typedef struct packed {
    logic      vld;
    lane_idx_t tag;
  } inflight_t;

endpackage

// File: rtl/sfu_rr_pick2.sv
// Combinational round-robin picker that selects up to two winners, starting the scan at i_rr_ptr.
// The first winner goes to port A; the second, later in scan order, goes to port B.
module sfu_rr_pick2
  import sfu_lut_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  lane_idx_t        i_rr_ptr,
  output logic [N_REQ-1:0] o_gnt_a,
  output logic [N_REQ-1:0] o_gnt_b,
  output logic             o_vld_a,
  output logic             o_vld_b
);

  // Pick the lowest requester at or above ptr; if there is none, wrap around to the lowest requester.
  function automatic logic [N_REQ-1:0] pick_first(input logic [N_REQ-1:0] req,
                                                  input lane_idx_t        ptr);
    logic [N_REQ-1:0] hi;
    logic [N_REQ-1:0] src;
    logic             found;
    pick_first = '0;
    found      = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      hi[j] = req[j] && (j >= int'(ptr));
    end
    src = (|hi) ? hi : req;
    for (int j = 0; j < N_REQ; j++) begin
      if (src[j] && !found) begin
        pick_first[j] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction

  logic [N_REQ-1:0] w_gnt_a;
  logic [N_REQ-1:0] w_gnt_b;

  // Removing winner A and scanning again from the same pointer yields the next lane in rotation order.
  assign w_gnt_a = pick_first(i_req, i_rr_ptr);
  assign w_gnt_b = pick_first(i_req & ~w_gnt_a, i_rr_ptr);

  assign o_gnt_a = w_gnt_a;
  assign o_gnt_b = w_gnt_b;
  assign o_vld_a = |w_gnt_a;
  assign o_vld_b = |w_gnt_b;

endmodule

// File: rtl/sfu_lut_port_arbiter.sv
// Shares the two read ports of the SFU exp lookup ROM between N_REQ lanes.
// Grants are combinational; each response returns to its lane two cycles after the grant.
module sfu_lut_port_arbiter
  import sfu_lut_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = LUT_ADDR_WIDTH,
  parameter int DATA_WIDTH = LUT_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            req_ready,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [N_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0]       lut_addr_a,
  output logic [ADDR_WIDTH-1:0]       lut_addr_b,
  output logic                        lut_we_a,
  output logic                        lut_we_b,
  input  logic [DATA_WIDTH-1:0]       lut_q_a,
  input  logic [DATA_WIDTH-1:0]       lut_q_b
);

  lane_idx_t                   r_rr_ptr;
  inflight_t                   r_stage_a;
  inflight_t                   r_stage_b;
  logic [N_REQ-1:0]            r_rsp_valid;
  logic [N_REQ*DATA_WIDTH-1:0] r_rsp_data;

  logic [N_REQ-1:0]            w_req;
  logic [N_REQ-1:0]            w_gnt_a;
  logic [N_REQ-1:0]            w_gnt_b;
  logic                        w_vld_a;
  logic                        w_vld_b;
  lane_idx_t                   w_idx_a;
  lane_idx_t                   w_idx_b;
  lane_idx_t                   w_last;
  lane_idx_t                   w_ptr_next;
  logic [ADDR_WIDTH-1:0]       w_addr_a;
  logic [ADDR_WIDTH-1:0]       w_addr_b;
  logic [N_REQ-1:0]            w_rsp_valid_next;
  logic [N_REQ*DATA_WIDTH-1:0] w_rsp_data_next;

  // Masking requests during reset suppresses every grant and idles both ports.
  assign w_req = rst_n ? req_valid : '0;

  sfu_rr_pick2 #(
    .N_REQ (N_REQ)
  ) u_pick (
    .i_req    (w_req),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt_a  (w_gnt_a),
    .o_gnt_b  (w_gnt_b),
    .o_vld_a  (w_vld_a),
    .o_vld_b  (w_vld_b)
  );

  always_comb begin
    w_idx_a  = '0;
    w_idx_b  = '0;
    w_addr_a = '0;
    w_addr_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_a[i]) begin
        w_idx_a  = lane_idx_t'(i);
        w_addr_a = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (w_gnt_b[i]) begin
        w_idx_b  = lane_idx_t'(i);
        w_addr_b = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Port B is granted only when port A is also granted, so B, if valid, is the last lane granted.
  assign w_last = w_vld_b ? w_idx_b : w_idx_a;

  always_comb begin
    w_ptr_next = r_rr_ptr;
    if (w_vld_a) begin
      w_ptr_next = (w_last == lane_idx_t'(N_REQ - 1)) ? '0 : w_last + lane_idx_t'(1);
    end
  end

  always_comb begin
    w_rsp_valid_next = '0;
    w_rsp_data_next  = r_rsp_data;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_stage_a.vld && r_stage_a.tag == lane_idx_t'(i)) begin
        w_rsp_valid_next[i]                       = 1'b1;
        w_rsp_data_next[i*DATA_WIDTH +: DATA_WIDTH] = lut_q_a;
      end
      if (r_stage_b.vld && r_stage_b.tag == lane_idx_t'(i)) begin
        w_rsp_valid_next[i]                       = 1'b1;
        w_rsp_data_next[i*DATA_WIDTH +: DATA_WIDTH] = lut_q_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_stage_a   <= '0;
      r_stage_b   <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rr_ptr    <= w_ptr_next;
      r_stage_a   <= '{vld: w_vld_a, tag: w_idx_a};
      r_stage_b   <= '{vld: w_vld_b, tag: w_idx_b};
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
    end
  end

  assign req_ready  = w_gnt_a | w_gnt_b;
  assign lut_addr_a = w_addr_a;
  assign lut_addr_b = w_addr_b;
  assign lut_we_a   = 1'b0;
  assign lut_we_b   = 1'b0;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;

endmodule

// File: tb/tb_sfu_lut_port_arbiter.sv
// Directed bench for sfu_lut_port_arbiter: a ROM model, a cycle-level reference model
// checked every cycle, and literal expectations taken from hand-worked scenarios.
module tb_sfu_lut_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [AW-1:0] lut_addr_a;
  logic [AW-1:0] lut_addr_b;
  logic          lut_we_a;
  logic          lut_we_b;
  logic [DW-1:0] lut_q_a;
  logic [DW-1:0] lut_q_b;

  int n_checks = 0;
  int n_errors = 0;

  sfu_lut_port_arbiter #(
    .N_REQ      (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .lut_addr_a (lut_addr_a),
    .lut_addr_b (lut_addr_b),
    .lut_we_a   (lut_we_a),
    .lut_we_b   (lut_we_b),
    .lut_q_a    (lut_q_a),
    .lut_q_b    (lut_q_b)
  );

  always #5 clk = ~clk;

  // ROM model: registered read, 1-cycle latency, output forced to 0 during reset.
  logic [DW-1:0] rom [32];
  initial begin
    for (int a = 0; a < 32; a++) rom[a] = DW'(a * 32'h1111 + 32'h321);
    rom[0]  = 20'h00267;
    rom[1]  = 20'h004AD;
    rom[2]  = 20'h006D2;
    rom[3]  = 20'h008D7;
    rom[5]  = 20'h00C7B;
    rom[16] = 20'h0160C;
    rom[31] = 20'h00004;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      lut_q_a <= '0;
      lut_q_b <= '0;
    end else begin
      lut_q_a <= rom[lut_addr_a];
      lut_q_b <= rom[lut_addr_b];
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: grant list built by walking the lanes in rotation order.
  function automatic void model_grant(input logic [N-1:0] v, input int ptr,
                                      output int a, output int b);
    a = -1;
    b = -1;
    for (int k = 0; k < N; k++) begin
      int l;
      l = (ptr + k) % N;
      if (v[l]) begin
        if (a < 0) a = l;
        else if (b < 0) b = l;
      end
    end
  endfunction

  function automatic logic [AW-1:0] lane_addr(input logic [N*AW-1:0] addrs, input int l);
    return addrs[l*AW +: AW];
  endfunction

  int            m_ptr = 0;
  logic [N-1:0]  m_s1_mask = '0;
  logic [DW-1:0] m_s1_data [N];
  logic [N-1:0]  m_out_mask = '0;
  logic [DW-1:0] m_out_data [N];
  bit            seen_reset = 1'b0;
  int            rsp_count [N];

  initial for (int l = 0; l < N; l++) begin
    rsp_count[l]  = 0;
    m_out_data[l] = '0;
    m_s1_data[l]  = '0;
  end

  always @(posedge clk) begin
    int a, b;
    if (!rst_n) begin
      m_ptr      = 0;
      m_s1_mask  = '0;
      m_out_mask = '0;
      for (int l = 0; l < N; l++) m_out_data[l] = '0;
      seen_reset = 1'b1;
    end else begin
      model_grant(req_valid, m_ptr, a, b);
      m_out_mask = m_s1_mask;
      for (int l = 0; l < N; l++) if (m_s1_mask[l]) m_out_data[l] = m_s1_data[l];
      m_s1_mask = '0;
      if (a >= 0) begin
        m_s1_mask[a] = 1'b1;
        m_s1_data[a] = rom[lane_addr(req_addr, a)];
        m_ptr = (a + 1) % N;
      end
      if (b >= 0) begin
        m_s1_mask[b] = 1'b1;
        m_s1_data[b] = rom[lane_addr(req_addr, b)];
        m_ptr = (b + 1) % N;
      end
    end
  end

  // Every-cycle compare, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (seen_reset) begin
      int a, b;
      logic [N-1:0]    e_ready;
      logic [AW-1:0]   e_addr_a;
      logic [AW-1:0]   e_addr_b;
      logic [N*DW-1:0] e_data;
      e_ready  = '0;
      e_addr_a = '0;
      e_addr_b = '0;
      if (rst_n) begin
        model_grant(req_valid, m_ptr, a, b);
        if (a >= 0) begin
          e_ready[a] = 1'b1;
          e_addr_a   = lane_addr(req_addr, a);
        end
        if (b >= 0) begin
          e_ready[b] = 1'b1;
          e_addr_b   = lane_addr(req_addr, b);
        end
      end
      for (int l = 0; l < N; l++) e_data[l*DW +: DW] = m_out_data[l];
      chk("model_ready", 128'(req_ready), 128'(e_ready));
      chk("model_addr_a", 128'(lut_addr_a), 128'(e_addr_a));
      chk("model_addr_b", 128'(lut_addr_b), 128'(e_addr_b));
      chk("model_we", 128'({lut_we_a, lut_we_b}), 128'(2'b00));
      chk("model_rsp_valid", 128'(rsp_valid), 128'(m_out_mask));
      chk("model_rsp_data", 128'(rsp_data), 128'(e_data));
      for (int l = 0; l < N; l++) if (rsp_valid[l] === 1'b1) rsp_count[l]++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int l, input logic [AW-1:0] a);
    req_valid[l] = 1'b1;
    req_addr[l*AW +: AW] = a;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int snap [N];

  initial begin
    do_reset();

    // Single request on lane 2.
    drive(2, 5'd16);
    @(negedge clk);
    chk("single_ready", 128'(req_ready), 128'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("single_rsp_valid", 128'(rsp_valid), 128'(4'b0100));
    chk("single_rsp_data2", 128'(rsp_data[2*DW +: DW]), 128'(20'h0160C));
    $display("single request: lane 2 addr 16 -> 0x%0h", rsp_data[2*DW +: DW]);

    // Dual grant followed directly by fairness run.
    do_reset();
    drive(0, 5'd0);
    drive(3, 5'd31);
    @(negedge clk);
    chk("dual_ready", 128'(req_ready), 128'(4'b1001));
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int l = 0; l < N; l++) drive(l, AW'(l * 8 + c));
      if (c == 2) for (int l = 0; l < N; l++) snap[l] = rsp_count[l];
      @(negedge clk);
      chk("fair_ready", 128'(req_ready), 128'((c % 2 == 0) ? 4'b0011 : 4'b1100));
      if (c == 1) begin
        chk("dual_rsp_valid", 128'(rsp_valid), 128'(4'b1001));
        chk("dual_rsp_data0", 128'(rsp_data[0*DW +: DW]), 128'(20'h00267));
        chk("dual_rsp_data3", 128'(rsp_data[3*DW +: DW]), 128'(20'h00004));
        $display("dual grant: lane0 0x%0h lane3 0x%0h", rsp_data[0*DW +: DW], rsp_data[3*DW +: DW]);
      end
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    for (int l = 0; l < N; l++) begin
      chk($sformatf("fair_count_lane%0d", l), 128'(rsp_count[l] - snap[l]), 128'(4));
    end
    $display("fairness: 8 cycles all lanes valid, responses per lane checked");

    // Same address on two lanes.
    drive(1, 5'd5);
    drive(2, 5'd5);
    @(negedge clk);
    chk("same_ready", 128'(req_ready), 128'(4'b0110));
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    chk("same_rsp_valid", 128'(rsp_valid), 128'(4'b0110));
    chk("same_rsp_data1", 128'(rsp_data[1*DW +: DW]), 128'(20'h00C7B));
    chk("same_rsp_data2", 128'(rsp_data[2*DW +: DW]), 128'(20'h00C7B));
    $display("same address: lanes 1,2 addr 5 -> 0x%0h", rsp_data[1*DW +: DW]);

    // Reset while reads are in flight.
    drive(0, 5'd7);
    drive(1, 5'd9);
    @(negedge clk);
    chk("rstmid_ready", 128'(req_ready), 128'(4'b0011));
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_ready_in_reset", 128'(req_ready), 128'(4'b0000));
    tick();
    rst_n = 1'b1;
    for (int l = 0; l < N; l++) drive(l, AW'(l + 20));
    @(negedge clk);
    chk("rstmid_rsp_valid", 128'(rsp_valid), 128'(4'b0000));
    chk("rstmid_rsp_data", 128'(rsp_data), 128'(0));
    chk("rstmid_ptr_release", 128'(req_ready), 128'(4'b0011));
    $display("reset mid-flight: in-flight reads dropped");
    tick();
    req_valid = '0;
    tick();
    tick();

    // Back-to-back requests from lane 0.
    drive(0, 5'd1);
    tick();
    drive(0, 5'd2);
    tick();
    drive(0, 5'd3);
    @(negedge clk);
    chk("b2b_rsp0_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("b2b_rsp0_data", 128'(rsp_data[0 +: DW]), 128'(20'h004AD));
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("b2b_rsp1_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("b2b_rsp1_data", 128'(rsp_data[0 +: DW]), 128'(20'h006D2));
    tick();
    @(negedge clk);
    chk("b2b_rsp2_valid", 128'(rsp_valid), 128'(4'b0001));
    chk("b2b_rsp2_data", 128'(rsp_data[0 +: DW]), 128'(20'h008D7));
    $display("back-to-back: lane 0 addrs 1,2,3 returned in order");
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
